i2c_master_xfer_ctrl: RTL and testbench

//  Parametrised byte/word-level I2C master sequencer; the next generation of the byte controller.

---
 rtl/i2c_master_xfer_ctrl_pkg.sv | 17 +
 rtl/i2c_master_xfer_ctrl_if.sv | 26 ++
 rtl/i2c_master_xfer_ctrl_shift_reg.sv | 20 ++
 rtl/i2c_master_xfer_ctrl.sv | 123 ++++++++++++
 tb/tb_i2c_master_xfer_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_master_xfer_ctrl_pkg.sv
// i2c_master_xfer_ctrl_pkg: bit-controller command codes and sequencer state encoding.
package i2c_master_xfer_ctrl_pkg;

    typedef logic [3:0] bit_cmd_t;

    // Same encoding the bit controller decodes.
    localparam bit_cmd_t I2C_CMD_NOP   = 4'b0000;
    localparam bit_cmd_t I2C_CMD_START = 4'b0001;
    localparam bit_cmd_t I2C_CMD_STOP  = 4'b0010;
    localparam bit_cmd_t I2C_CMD_WRITE = 4'b0100;
    localparam bit_cmd_t I2C_CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_LOAD, ST_BITS, ST_ACK, ST_STOP, ST_DONE
    } state_t;

endpackage

// File: rtl/i2c_master_xfer_ctrl_if.sv
// i2c_master_xfer_ctrl_if: register-side command/data handshakes plus bit-controller link.
interface i2c_master_xfer_ctrl_if
    import i2c_master_xfer_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              start, stop, read, write, tx_ack;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] tx_data, rx_data;
    logic              tx_valid, tx_ready, rx_valid, rx_ack;
    logic              i2c_busy, i2c_done, al_err;
    bit_cmd_t          bit_cmd;
    logic              bit_txd, bit_ack, bit_rxd, i2c_al;

    modport master (
        input  start, stop, read, write, tx_ack, len, tx_data, tx_valid, bit_ack, bit_rxd, i2c_al,
        output tx_ready, rx_data, rx_valid, rx_ack, i2c_busy, i2c_done, al_err, bit_cmd, bit_txd
    );

    modport slave (
        output start, stop, read, write, tx_ack, len, tx_data, tx_valid, bit_ack, bit_rxd, i2c_al,
        input  tx_ready, rx_data, rx_valid, rx_ack, i2c_busy, i2c_done, al_err, bit_cmd, bit_txd
    );

endinterface

// File: rtl/i2c_master_xfer_ctrl_shift_reg.sv
// i2c_shift_reg: parallel-load word register, shifts MSB out / LSB in on enable.
module i2c_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_en,
    input  logic              shift_in,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) q <= '0;
        else if (load) q <= load_data;
        else if (shift_en) q <= {q[DATA_W-2:0], shift_in};
    end

endmodule

// File: rtl/i2c_master_xfer_ctrl.sv
// i2c_master_xfer_ctrl: word-level I2C sequencer driving START, a burst of ACKed words and STOP
// through the bit controller, with per-word Tx/Rx handshakes, NACK abort and arbitration-loss abort.
module i2c_master_xfer_ctrl
    import i2c_master_xfer_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input logic clk,
    input logic rst_n,
    i2c_master_xfer_ctrl_if.master bus
);

    localparam int CW = $clog2(DATA_W + 1);

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [LEN_W-1:0]  word_cnt;
    logic              rd_q, wr_q, stop_q, tx_ack_q;
    logic [DATA_W-1:0] shift_q;
    logic              acked, load, shift_en, txd;
    bit_cmd_t          cmd;

    // A Bit_ack only counts against a command actually on the wire.
    assign acked    = bus.bit_ack && bus.bit_cmd != I2C_CMD_NOP;
    assign load     = state == ST_LOAD && wr_q && bus.tx_valid;
    assign shift_en = state == ST_BITS && acked;
    // Data phase and ACK phase use opposite directions.
    assign cmd = state == ST_START ? I2C_CMD_START :
                 state == ST_STOP  ? I2C_CMD_STOP  :
                 ((state == ST_BITS) == rd_q) ? I2C_CMD_READ : I2C_CMD_WRITE;
    assign txd = state == ST_BITS ? wr_q & shift_q[DATA_W-1] :
                 (state == ST_ACK) & rd_q & (word_cnt == LEN_W'(1)) & tx_ack_q;

    i2c_shift_reg #(.DATA_W(DATA_W)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (bus.tx_data),
        .shift_en  (shift_en),
        .shift_in  (bus.bit_rxd),
        .q         (shift_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bus.bit_cmd  <= I2C_CMD_NOP;
            bus.bit_txd  <= 1'b0;
            bus.tx_ready <= 1'b0;
            bus.rx_valid <= 1'b0;
            bus.rx_ack   <= 1'b0;
            bus.i2c_busy <= 1'b0;
            bus.i2c_done <= 1'b0;
            bus.al_err   <= 1'b0;
            bus.rx_data  <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            {rd_q, wr_q, stop_q, tx_ack_q} <= '0;
        end else begin
            bus.tx_ready <= 1'b0;
            bus.rx_valid <= 1'b0;
            bus.i2c_done <= 1'b0;
            if (state != ST_IDLE && bus.i2c_al) begin
                state        <= ST_IDLE;
                bus.bit_cmd  <= I2C_CMD_NOP;
                bus.al_err   <= 1'b1;
                bus.i2c_done <= 1'b1;
                bus.i2c_busy <= 1'b0;
            end else if (acked) begin
                bus.bit_cmd <= I2C_CMD_NOP;
                case (state)
                    ST_START: state <= (rd_q || wr_q) ? ST_LOAD : stop_q ? ST_STOP : ST_DONE;
                    ST_BITS: begin
                        bit_cnt <= bit_cnt - 1'b1;
                        if (bit_cnt == CW'(1)) state <= ST_ACK;
                    end
                    ST_ACK: begin
                        if (wr_q) bus.rx_ack <= bus.bit_rxd;
                        if (word_cnt > LEN_W'(1) && !(wr_q && bus.bit_rxd)) begin
                            word_cnt <= word_cnt - 1'b1;
                            state    <= ST_LOAD;
                        end else state <= stop_q ? ST_STOP : ST_DONE;
                    end
                    default: state <= ST_DONE;
                endcase
            end else begin
                case (state)
                    ST_IDLE: if (bus.start || bus.stop || bus.read || bus.write) begin
                        state        <= bus.start ? ST_START : (bus.read || bus.write) ? ST_LOAD : ST_STOP;
                        rd_q         <= bus.read;
                        wr_q         <= bus.write && !bus.read;
                        stop_q       <= bus.stop;
                        tx_ack_q     <= bus.tx_ack;
                        word_cnt     <= (bus.len == '0) ? LEN_W'(1) : bus.len;
                        bus.i2c_busy <= 1'b1;
                        bus.al_err   <= 1'b0;
                    end
                    ST_LOAD: if (rd_q || bus.tx_valid) begin
                        bus.tx_ready <= wr_q;
                        bit_cnt      <= CW'(DATA_W);
                        state        <= ST_BITS;
                    end
                    ST_DONE: begin
                        state        <= ST_IDLE;
                        bus.i2c_done <= 1'b1;
                        bus.i2c_busy <= 1'b0;
                    end
                    // START/BITS/ACK/STOP: issue once per state entry or per bit.
                    default: if (bus.bit_cmd == I2C_CMD_NOP) begin
                        bus.bit_cmd <= cmd;
                        bus.bit_txd <= txd;
                        if (state == ST_ACK && rd_q) begin
                            bus.rx_data  <= shift_q;
                            bus.rx_valid <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_xfer_ctrl.sv
// tb_i2c_master_xfer_ctrl: directed and random bursts against a transaction-level model of
// the expected bit-command stream, handshakes and received words.
module tb_i2c_master_xfer_ctrl;
    import i2c_master_xfer_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_master_xfer_ctrl_if #(.DATA_W(8), .LEN_W(4))  bus();
    i2c_master_xfer_ctrl_if #(.DATA_W(10), .LEN_W(4)) bus10();

    i2c_master_xfer_ctrl #(.DATA_W(8), .LEN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    i2c_master_xfer_ctrl #(.DATA_W(10), .LEN_W(4)) dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus10)
    );

    int cmps = 0;
    int fails = 0;
    logic [4:0] exp_log[$], got_log[$];
    logic [7:0] wq[$], sq[$], exp_rx[$], got_rx[$];
    logic       rq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmps++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete command: model the expected stream, then play bit controller and register side.
    task automatic run(input bit s, p, rd, wr, ta, input int len, nack, stall, al_at);
        int n, exp_tx, tx_cnt, ti, dly, rise, first_rdy, busy_low, extra;
        bit w, got_done, al_hit, exp_rack;
        n = (len == 0) ? 1 : len;
        w = wr && !rd;
        {exp_tx, tx_cnt, ti, dly, busy_low, extra} = '0;
        {got_done, al_hit, exp_rack} = '0;
        rise = -1;
        first_rdy = -1;
        exp_log.delete(); got_log.delete(); rq.delete(); exp_rx.delete(); got_rx.delete();
        if (s) exp_log.push_back({I2C_CMD_START, 1'b0});
        if (rd || wr) for (int k = 0; k < n; k++) begin
            if (w) begin
                for (int b = 7; b >= 0; b--) exp_log.push_back({I2C_CMD_WRITE, wq[k][b]});
                exp_log.push_back({I2C_CMD_READ, 1'b0});
                rq.push_back(k == nack);
                exp_tx++;
                exp_rack = (k == nack);
                if (k == nack) break;
            end else begin
                for (int b = 7; b >= 0; b--) begin
                    exp_log.push_back({I2C_CMD_READ, 1'b0});
                    rq.push_back(sq[k][b]);
                end
                exp_rx.push_back(sq[k]);
                exp_log.push_back({I2C_CMD_WRITE, (k == n - 1) ? ta : 1'b0});
            end
        end
        if (p) exp_log.push_back({I2C_CMD_STOP, 1'b0});
        if (al_at >= 0) while (exp_log.size() > al_at) void'(exp_log.pop_back());

        @(negedge clk);
        {bus.start, bus.stop, bus.read, bus.write, bus.tx_ack} = {s, p, rd, wr, ta};
        bus.len = 4'(len);
        @(negedge clk);
        {bus.start, bus.stop, bus.read, bus.write} = '0;
        chk("busy_on_accept", bus.i2c_busy, 1);
        chk("al_err_cleared", bus.al_err, 0);
        for (int cyc = 1; cyc <= 3000 && !got_done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            got_done = bus.i2c_done;
            if (!bus.i2c_busy && !got_done) busy_low++;
            if (bus.tx_ready) begin
                tx_cnt++;
                ti++;
                if (first_rdy < 0) first_rdy = cyc;
            end
            if (bus.rx_valid) got_rx.push_back(bus.rx_data);
            if (cyc <= stall) chk("nop_while_stalled", bus.bit_cmd, I2C_CMD_NOP);
            if (bus.i2c_al) bus.i2c_al = 1'b0;
            else if (bus.bit_ack) bus.bit_ack = 1'b0;
            else if (bus.bit_cmd != I2C_CMD_NOP && !got_done) begin
                if (got_log.size() == al_at && !al_hit) begin
                    bus.i2c_al = 1'b1;
                    al_hit = 1'b1;
                end else if (dly > 0) dly--;
                else begin
                    got_log.push_back({bus.bit_cmd, bus.bit_cmd == I2C_CMD_WRITE && bus.bit_txd});
                    bus.bit_rxd = (bus.bit_cmd == I2C_CMD_READ && rq.size() > 0) ? rq.pop_front() : 1'b0;
                    bus.bit_ack = 1'b1;
                    dly = $urandom_range(0, 2);
                end
            end else if (stall > 0 && cyc == stall / 2) bus.bit_ack = 1'b1;
            bus.tx_valid = (ti < n) && w && (cyc > stall) && !got_done;
            bus.tx_data = (ti < wq.size()) ? wq[ti] : 8'h00;
            if (bus.tx_valid && rise < 0) rise = cyc;
        end
        bus.tx_valid = 1'b0;
        chk("done_seen", got_done, 1);
        chk("busy_low_at_done", bus.i2c_busy, 0);
        chk("cmd_nop_at_done", bus.bit_cmd, I2C_CMD_NOP);
        chk("al_err_at_done", bus.al_err, al_at >= 0);
        chk("busy_held", busy_low, 0);
        chk("log_len", got_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++)
            chk($sformatf("log[%0d]", i), (i < got_log.size()) ? got_log[i] : 5'h1f, exp_log[i]);
        if (al_at < 0) begin
            chk("tx_ready_count", tx_cnt, exp_tx);
            chk("rx_count", got_rx.size(), exp_rx.size());
            for (int i = 0; i < exp_rx.size(); i++)
                chk($sformatf("rx[%0d]", i), (i < got_rx.size()) ? got_rx[i] : 8'hxx, exp_rx[i]);
            if (w) chk("rx_ack", bus.rx_ack, exp_rack);
        end
        if (stall > 0) chk("resume_latency", first_rdy - rise, 1);
        repeat (3) begin
            @(negedge clk);
            if (bus.i2c_done) extra++;
        end
        chk("single_done", extra, 0);
    endtask

    task automatic serve10(input int max_acks, input logic [9:0] word, output int acks,
                           output bit done10, output bit rv, output logic [9:0] rx, output bit last_txd);
        int reads;
        reads = 0;
        acks = 0;
        {done10, rv, last_txd} = '0;
        rx = '0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus10.i2c_done) done10 = 1'b1;
            if (bus10.rx_valid) begin
                rv = 1'b1;
                rx = bus10.rx_data;
            end
            if (bus10.bit_ack) bus10.bit_ack = 1'b0;
            else if (bus10.bit_cmd != I2C_CMD_NOP && acks < max_acks) begin
                if (bus10.bit_cmd == I2C_CMD_READ) begin
                    bus10.bit_rxd = (reads < 10) ? word[9 - reads] : 1'b0;
                    reads++;
                end else last_txd = bus10.bit_txd;
                bus10.bit_ack = 1'b1;
                acks++;
            end
            if (done10 || (acks >= max_acks && !bus10.bit_ack)) break;
        end
    endtask

    initial begin
        int acks;
        bit d10, rv10, ltx;
        logic [9:0] rx10;
        bit rd, wr;
        int mode, nack;
        {bus.start, bus.stop, bus.read, bus.write, bus.tx_ack, bus.tx_valid} = '0;
        {bus.bit_ack, bus.bit_rxd, bus.i2c_al} = '0;
        bus.len = '0;
        bus.tx_data = '0;
        {bus10.start, bus10.stop, bus10.read, bus10.write, bus10.tx_ack, bus10.tx_valid} = '0;
        {bus10.bit_ack, bus10.bit_rxd, bus10.i2c_al} = '0;
        bus10.len = '0;
        bus10.tx_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.bit_cmd, bus.bit_txd, bus.tx_ready, bus.rx_valid, bus.rx_ack,
                              bus.i2c_busy, bus.i2c_done, bus.al_err}, 0);
        chk("reset_rx_data", bus.rx_data, 0);
        rst_n = 1'b1;

        wq = '{8'hA5, 8'h3C};
        run(1, 1, 0, 1, 0, 2, -1, 0, -1);
        sq = '{8'h11, 8'h22, 8'h33};
        run(1, 1, 1, 0, 1, 3, -1, 0, -1);
        wq = '{8'h5A, 8'hC3, 8'h96};
        run(1, 1, 0, 1, 0, 3, 0, 0, -1);
        wq = '{8'h81};
        run(0, 1, 0, 1, 0, 1, -1, 20, -1);
        wq = '{8'hF0, 8'h0F};
        run(1, 1, 0, 1, 0, 2, -1, 0, 4);
        run(1, 1, 0, 0, 0, 0, -1, 0, -1);
        run(0, 1, 0, 0, 0, 0, -1, 0, -1);
        for (int t = 0; t < 8; t++) begin
            wq.delete();
            sq.delete();
            for (int k = 0; k < 4; k++) begin
                wq.push_back(8'($urandom));
                sq.push_back(8'($urandom));
            end
            mode = $urandom_range(0, 2);
            rd = (mode != 1);
            wr = (mode != 0);
            nack = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            run(1'($urandom), 1'($urandom), rd, wr, 1'($urandom), $urandom_range(0, 4), nack, 0, -1);
        end

        @(negedge clk);
        {bus10.start, bus10.read, bus10.stop} = 3'b111;
        @(negedge clk);
        {bus10.start, bus10.read, bus10.stop} = 3'b000;
        serve10(5, 10'h3FF, acks, d10, rv10, rx10, ltx);
        chk("w10_partial_acks", acks, 5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("w10_reset_outputs", {bus10.bit_cmd, bus10.bit_txd, bus10.tx_ready, bus10.rx_valid,
                                  bus10.rx_ack, bus10.i2c_busy, bus10.i2c_done, bus10.al_err}, 0);
        chk("w10_reset_rx_data", bus10.rx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        bus10.read = 1'b1;
        bus10.tx_ack = 1'b1;
        @(negedge clk);
        bus10.read = 1'b0;
        serve10(100, 10'h2A5, acks, d10, rv10, rx10, ltx);
        chk("w10_acks", acks, 11);
        chk("w10_done", d10, 1);
        chk("w10_rx_valid", rv10, 1);
        chk("w10_rx_data", rx10, 10'h2A5);
        chk("w10_last_ack_bit", ltx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end

endmodule
